// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and helpers for the multi-port register file.
//   DATA_W_DEF / NUM_REGS_DEF / NUM_RD_DEF : default parameter values
//   slice_lo()                             : low bit of port/word i in a packed bus
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 16;
  localparam int NUM_RD_DEF   = 2;

  // Packed buses (rd_addr, rd_data, dbg_regs) place element i at [i*width +: width].
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// regfile_if: bundle of the register file's writeback, load and read signals.
//   slave  : register file side (takes writes/loads/read addresses, drives read data and status)
//   master : pipeline/memory side (the reverse directions)
// clk and reset_n are not part of the bundle.
interface regfile_if import regfile_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = NUM_RD_DEF
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       ld_req;
  logic [ADDR_W-1:0]          ld_req_addr;
  logic                       ld_valid;
  logic [ADDR_W-1:0]          ld_rsp_addr;
  logic [DATA_W-1:0]          ld_data;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_busy;
  logic [NUM_REGS-1:0]        pending;
  logic [ADDR_W:0]            pending_cnt;
  logic                       wr_hazard;
  logic                       ld_err;
  logic [NUM_REGS*DATA_W-1:0] dbg_regs;

  modport slave (
    input  wr_en, wr_addr, wr_data, ld_req, ld_req_addr,
           ld_valid, ld_rsp_addr, ld_data, rd_addr,
    output rd_data, rd_busy, pending, pending_cnt, wr_hazard, ld_err, dbg_regs
  );

  modport master (
    output wr_en, wr_addr, wr_data, ld_req, ld_req_addr,
           ld_valid, ld_rsp_addr, ld_data, rd_addr,
    input  rd_data, rd_busy, pending, pending_cnt, wr_hazard, ld_err, dbg_regs
  );

endinterface

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port of the register file.
//   addr       : register index to read
//   regs_flat  : all register words, word i at [i*DATA_W +: DATA_W]
//   pending    : scoreboard vector
//   wr_commit/wr_addr/wr_data : ALU write that will commit at the next edge
//   ld_commit/ld_addr/ld_data : load return that will commit at the next edge
//   data, busy : read data and pending flag for addr
// With REGFILE_BYPASS_EN defined, same-cycle commits are forwarded (load before ALU)
// and a register being returned this cycle is not reported busy.
module regfile_rd_port import regfile_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic [ADDR_W-1:0]          addr,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic [NUM_REGS-1:0]        pending,
  input  logic                       wr_commit,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       ld_commit,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [DATA_W-1:0]          ld_data,
  output logic [DATA_W-1:0]          data,
  output logic                       busy
);

  always_comb begin
    data = regs_flat[slice_lo(int'(addr), DATA_W) +: DATA_W];
    busy = pending[addr];
`ifdef REGFILE_BYPASS_EN
    // wr_commit is already false when it collides with a load return,
    // so a dropped write can never be forwarded here.
    if (ld_commit && (ld_addr == addr)) begin
      data = ld_data;
      busy = 1'b0;
    end else if (wr_commit && (wr_addr == addr)) begin
      data = wr_data;
    end
`endif
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wr_commit, wr_addr, wr_data, ld_commit, ld_addr, ld_data};
`endif

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a load scoreboard.
//   clk, reset_n : rising-edge clock, asynchronous active-low reset
//   bus          : regfile_if.slave -- ALU writeback, load request/return,
//                  NUM_RD read ports, scoreboard status, error pulses, debug view
// Parameters: DATA_W, NUM_REGS (power of two), NUM_RD, ZERO_R0 (r0 hardwired to 0).
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter bit ZERO_R0  = 1'b0
) (
  input  logic     clk,
  input  logic     reset_n,
  regfile_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int CNT_W  = ADDR_W + 1;

  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic [NUM_REGS-1:0]        pending_reg, pending_next;
  logic [CNT_W-1:0]           pending_cnt_reg, pending_cnt_next;
  logic                       wr_hazard_reg, wr_hazard_next;
  logic                       ld_err_reg, ld_err_next;

  logic wr_live, req_live, rsp_live;
  logic rsp_hits_req, rsp_hits_wr;
  logic req_accept, wr_commit;
  logic cnt_inc, cnt_dec;

  // Event qualification and scoreboard next state.
  always_comb begin
    // With ZERO_R0, anything aimed at r0 vanishes before it can touch state or flag an error.
    wr_live  = bus.wr_en    && !(ZERO_R0 && (bus.wr_addr     == '0));
    req_live = bus.ld_req   && !(ZERO_R0 && (bus.ld_req_addr == '0));
    rsp_live = bus.ld_valid && !(ZERO_R0 && (bus.ld_rsp_addr == '0));

    rsp_hits_req = rsp_live && req_live && (bus.ld_rsp_addr == bus.ld_req_addr);
    rsp_hits_wr  = rsp_live && (bus.ld_rsp_addr == bus.wr_addr);

    // A re-request of a pending register is fine only if its old load retires this cycle.
    req_accept = req_live && (!pending_reg[bus.ld_req_addr] || rsp_hits_req);
    wr_commit  = wr_live && !pending_reg[bus.wr_addr] && !rsp_hits_wr;

    // Counter moves only when a bit actually flips; a retire+reissue on the same
    // register leaves it set and the count unchanged.
    cnt_inc = req_accept && !pending_reg[bus.ld_req_addr];
    cnt_dec = rsp_live && pending_reg[bus.ld_rsp_addr] && !rsp_hits_req;

    pending_next = pending_reg;
    if (rsp_live)   pending_next[bus.ld_rsp_addr] = 1'b0;
    if (req_accept) pending_next[bus.ld_req_addr] = 1'b1;

    pending_cnt_next = pending_cnt_reg + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    wr_hazard_next   = wr_live && !wr_commit;
    ld_err_next      = (req_live && !req_accept) ||
                       (rsp_live && !pending_reg[bus.ld_rsp_addr]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_reg     <= '0;
      pending_cnt_reg <= '0;
      wr_hazard_reg   <= 1'b0;
      ld_err_reg      <= 1'b0;
    end else begin
      pending_reg     <= pending_next;
      pending_cnt_reg <= pending_cnt_next;
      wr_hazard_reg   <= wr_hazard_next;
      ld_err_reg      <= ld_err_next;
    end
  end

  // One storage word per register; a load return beats an ALU write to the same word.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] word_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          word_reg <= '0;
        end else if (rsp_live && (bus.ld_rsp_addr == ADDR_W'(gi))) begin
          word_reg <= bus.ld_data;
        end else if (wr_commit && (bus.wr_addr == ADDR_W'(gi))) begin
          word_reg <= bus.wr_data;
        end
      end
      assign regs_flat[slice_lo(gi, DATA_W) +: DATA_W] = word_reg;
    end
  endgenerate

  logic [NUM_RD*DATA_W-1:0] rd_data_flat;
  logic [NUM_RD-1:0]        rd_busy_flat;

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      regfile_rd_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
      ) u_rd_port (
        .addr      (bus.rd_addr[slice_lo(gi, ADDR_W) +: ADDR_W]),
        .regs_flat (regs_flat),
        .pending   (pending_reg),
        .wr_commit (wr_commit),
        .wr_addr   (bus.wr_addr),
        .wr_data   (bus.wr_data),
        .ld_commit (rsp_live),
        .ld_addr   (bus.ld_rsp_addr),
        .ld_data   (bus.ld_data),
        .data      (rd_data_flat[slice_lo(gi, DATA_W) +: DATA_W]),
        .busy      (rd_busy_flat[gi])
      );
    end
  endgenerate

  assign bus.rd_data     = rd_data_flat;
  assign bus.rd_busy     = rd_busy_flat;
  assign bus.pending     = pending_reg;
  assign bus.pending_cnt = pending_cnt_reg;
  assign bus.wr_hazard   = wr_hazard_reg;
  assign bus.ld_err      = ld_err_reg;
  assign bus.dbg_regs    = regs_flat;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp.
// Instance dut  : defaults (32-bit, 16 regs, 2 read ports, ZERO_R0=0), checked against
//                 an array/scoreboard reference model with directed and random traffic.
// Instance dutz : 32 regs, 3 read ports, ZERO_R0=1, checked with directed r0 traffic.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW   = 32;
  localparam int NR   = 16;
  localparam int NRD  = 2;
  localparam int AW   = 4;
  localparam int NRZ  = 32;
  localparam int NRDZ = 3;
  localparam int AWZ  = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  regfile_if #(.DATA_W(DW), .NUM_REGS(NR),  .NUM_RD(NRD))  bus_a ();
  regfile_if #(.DATA_W(DW), .NUM_REGS(NRZ), .NUM_RD(NRDZ)) bus_z ();

  regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .ZERO_R0(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );
  regfile_mp #(.DATA_W(DW), .NUM_REGS(NRZ), .NUM_RD(NRDZ), .ZERO_R0(1'b1)) dutz (
    .clk(clk), .reset_n(reset_n), .bus(bus_z)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: register contents and outstanding loads as plain arrays.
  logic [DW-1:0] m_regs [NR];
  bit            m_pend [NR];
  bit            m_haz;
  bit            m_err;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NR; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic logic [NR-1:0] m_pend_vec();
    logic [NR-1:0] v = '0;
    for (int i = 0; i < NR; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [NR*DW-1:0] m_flat();
    logic [NR*DW-1:0] v = '0;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_regs[i];
    return v;
  endfunction

  // One cycle of events applied to the model, following the register file's rules.
  task automatic model_step(input bit we, input int wa, input logic [DW-1:0] wd,
                            input bit lr, input int lra,
                            input bit lv, input int lva, input logic [DW-1:0] ld);
    bit old [NR];
    bit req_ignored;
    old = m_pend;
    req_ignored = lr && old[lra] && !(lv && (lva == lra));
    m_haz = we && (old[wa] || (lv && (lva == wa)));
    m_err = (lv && !old[lva]) || req_ignored;
    if (we && !m_haz) m_regs[wa] = wd;
    if (lv) begin
      m_regs[lva] = ld;
      m_pend[lva] = 1'b0;
    end
    if (lr && !req_ignored) m_pend[lra] = 1'b1;
  endtask

  task automatic drive(input bit we, input int wa, input logic [DW-1:0] wd,
                       input bit lr, input int lra,
                       input bit lv, input int lva, input logic [DW-1:0] ld);
    bus_a.wr_en       = we;
    bus_a.wr_addr     = AW'(wa);
    bus_a.wr_data     = wd;
    bus_a.ld_req      = lr;
    bus_a.ld_req_addr = AW'(lra);
    bus_a.ld_valid    = lv;
    bus_a.ld_rsp_addr = AW'(lva);
    bus_a.ld_data     = ld;
    model_step(we, wa, wd, lr, lra, lv, lva, ld);
  endtask

  task automatic idle_all();
    bus_a.wr_en = 1'b0; bus_a.ld_req = 1'b0; bus_a.ld_valid = 1'b0;
    bus_z.wr_en = 1'b0; bus_z.ld_req = 1'b0; bus_z.ld_valid = 1'b0;
  endtask

  // Clock edge, then drop strobes so reads show committed state only.
  task automatic tick();
    @(posedge clk);
    #1;
    idle_all();
    #1;
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_haz = 1'b0;
    m_err = 1'b0;
    #2;
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    release_reset();
    for (int i = 0; i < NR; i++) begin
      drive(1'b1, i, $urandom, 1'b0, 0, 1'b0, 0, '0);
      tick();
    end
    drive(1'b0, 0, '0, 1'b1, 3, 1'b0, 0, '0);
    tick();
    checks++;
    if (bus_a.dbg_regs !== m_flat()) begin
      failures++;
      $display("FAIL preload got=%h exp=%h", bus_a.dbg_regs, m_flat());
    end
    assert_reset();
    checks++;
    if (bus_a.dbg_regs !== '0) begin
      failures++;
      $display("FAIL reset_regs got=%h exp=0", bus_a.dbg_regs);
    end
    checks++;
    if (bus_a.pending !== '0 || bus_a.pending_cnt !== '0) begin
      failures++;
      $display("FAIL reset_pending got=%h/%0d exp=0/0", bus_a.pending, bus_a.pending_cnt);
    end
    checks++;
    if (bus_a.wr_hazard !== 1'b0 || bus_a.ld_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses got=%b%b exp=00", bus_a.wr_hazard, bus_a.ld_err);
    end
    checks++;
    if (bus_z.pending !== '0 || bus_z.pending_cnt !== '0) begin
      failures++;
      $display("FAIL reset_z_pending got=%h/%0d exp=0/0", bus_z.pending, bus_z.pending_cnt);
    end
    release_reset();
    $display("txn reset: regs preloaded then cleared");
  endtask

  task automatic test_write_read();
    logic [DW-1:0] old3;
    logic [DW-1:0] exp_now;
    old3 = m_regs[3];
    drive(1'b1, 3, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 0, '0);
    bus_a.rd_addr = {AW'(3), AW'(3)};
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_now = 32'hDEAD_BEEF;
`else
    exp_now = old3;
`endif
    checks++;
    if (bus_a.rd_data[DW-1:0] !== exp_now) begin
      failures++;
      $display("FAIL write_same_cycle got=%h exp=%h", bus_a.rd_data[DW-1:0], exp_now);
    end
    tick();
    checks++;
    if (bus_a.rd_data !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL write_next_cycle got=%h exp=%h", bus_a.rd_data, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
    end
    $display("txn write r3=deadbeef");
  endtask

  task automatic test_waw_hazard();
    drive(1'b0, 0, '0, 1'b1, 5, 1'b0, 0, '0);
    tick();
    checks++;
    if (bus_a.pending !== 16'h0020 || bus_a.pending_cnt !== 5'd1 || bus_a.ld_err !== 1'b0) begin
      failures++;
      $display("FAIL ld_req5 got=%h/%0d/%b exp=0020/1/0", bus_a.pending, bus_a.pending_cnt, bus_a.ld_err);
    end
    drive(1'b0, 0, '0, 1'b1, 5, 1'b0, 0, '0);
    tick();
    checks++;
    if (bus_a.ld_err !== 1'b1 || bus_a.pending_cnt !== 5'd1) begin
      failures++;
      $display("FAIL ld_req_dup got=%b/%0d exp=1/1", bus_a.ld_err, bus_a.pending_cnt);
    end
    drive(1'b1, 5, 32'h0000_CAFE, 1'b0, 0, 1'b0, 0, '0);
    bus_a.rd_addr = {AW'(0), AW'(5)};
    tick();
    checks++;
    if (bus_a.wr_hazard !== 1'b1 || bus_a.rd_data[DW-1:0] !== m_regs[5] || bus_a.rd_busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL waw got=%b/%h/%b exp=1/%h/1", bus_a.wr_hazard, bus_a.rd_data[DW-1:0], bus_a.rd_busy[0], m_regs[5]);
    end
    drive(1'b0, 0, '0, 1'b0, 0, 1'b1, 5, 32'h0000_1234);
    tick();
    checks++;
    if (bus_a.rd_data[DW-1:0] !== 32'h0000_1234 || bus_a.pending_cnt !== 5'd0 ||
        bus_a.pending !== '0 || bus_a.ld_err !== 1'b0 || bus_a.rd_busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL ld_ret5 got=%h/%0d/%h/%b/%b exp=00001234/0/0/0/0", bus_a.rd_data[DW-1:0],
               bus_a.pending_cnt, bus_a.pending, bus_a.ld_err, bus_a.rd_busy[0]);
    end
    $display("txn waw guard on r5 then load return 1234");
  endtask

  task automatic test_simultaneous();
    drive(1'b0, 0, '0, 1'b1, 7, 1'b0, 0, '0);
    tick();
    drive(1'b1, 7, 32'h0BAD_0BAD, 1'b1, 7, 1'b1, 7, 32'h7777_0007);
    tick();
    checks++;
    if (bus_a.dbg_regs[7*DW +: DW] !== 32'h7777_0007) begin
      failures++;
      $display("FAIL simul_data got=%h exp=77770007", bus_a.dbg_regs[7*DW +: DW]);
    end
    checks++;
    if (bus_a.pending[7] !== 1'b1 || bus_a.wr_hazard !== 1'b1 ||
        bus_a.pending_cnt !== 5'd1 || bus_a.ld_err !== 1'b0) begin
      failures++;
      $display("FAIL simul_flags got=%b/%b/%0d/%b exp=1/1/1/0", bus_a.pending[7], bus_a.wr_hazard,
               bus_a.pending_cnt, bus_a.ld_err);
    end
    drive(1'b0, 0, '0, 1'b0, 0, 1'b1, 7, 32'h0000_0077);
    tick();
    checks++;
    if (bus_a.pending_cnt !== 5'd0 || bus_a.ld_err !== 1'b0) begin
      failures++;
      $display("FAIL simul_drain got=%0d/%b exp=0/0", bus_a.pending_cnt, bus_a.ld_err);
    end
    $display("txn r7 return+request+write same cycle");
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 0, '0, 1'b1, i, 1'b0, 0, '0);
      tick();
    end
    checks++;
    if (bus_a.pending_cnt !== 5'd4 || bus_a.pending !== 16'h001E) begin
      failures++;
      $display("FAIL four_loads got=%0d/%h exp=4/001e", bus_a.pending_cnt, bus_a.pending);
    end
    assert_reset();
    checks++;
    if (bus_a.pending !== '0 || bus_a.pending_cnt !== '0) begin
      failures++;
      $display("FAIL mid_reset got=%h/%0d exp=0/0", bus_a.pending, bus_a.pending_cnt);
    end
    release_reset();
    drive(1'b0, 0, '0, 1'b0, 0, 1'b1, 2, 32'h0000_55AA);
    tick();
    checks++;
    if (bus_a.dbg_regs[2*DW +: DW] !== 32'h0000_55AA || bus_a.ld_err !== 1'b1 || bus_a.pending_cnt !== '0) begin
      failures++;
      $display("FAIL stale_return got=%h/%b/%0d exp=000055aa/1/0", bus_a.dbg_regs[2*DW +: DW],
               bus_a.ld_err, bus_a.pending_cnt);
    end
    $display("txn reset with four loads outstanding, stale return to r2");
  endtask

  task automatic test_zero_r0();
    bus_z.rd_addr = '0;
    bus_z.wr_en = 1'b1; bus_z.wr_addr = AWZ'(0); bus_z.wr_data = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (bus_z.rd_data !== '0 || bus_z.wr_hazard !== 1'b0 || bus_z.ld_err !== 1'b0) begin
      failures++;
      $display("FAIL r0_write got=%h/%b/%b exp=0/0/0", bus_z.rd_data, bus_z.wr_hazard, bus_z.ld_err);
    end
    bus_z.ld_req = 1'b1; bus_z.ld_req_addr = AWZ'(0);
    tick();
    checks++;
    if (bus_z.pending !== '0 || bus_z.pending_cnt !== '0 || bus_z.ld_err !== 1'b0 || bus_z.rd_busy !== '0) begin
      failures++;
      $display("FAIL r0_ldreq got=%h/%0d/%b/%b exp=0/0/0/0", bus_z.pending, bus_z.pending_cnt,
               bus_z.ld_err, bus_z.rd_busy);
    end
    bus_z.ld_valid = 1'b1; bus_z.ld_rsp_addr = AWZ'(0); bus_z.ld_data = 32'h0000_0077;
    tick();
    checks++;
    if (bus_z.rd_data !== '0 || bus_z.ld_err !== 1'b0) begin
      failures++;
      $display("FAIL r0_ldvalid got=%h/%b exp=0/0", bus_z.rd_data, bus_z.ld_err);
    end
    bus_z.wr_en = 1'b1; bus_z.wr_addr = AWZ'(25); bus_z.wr_data = 32'hA5A5_5A5A;
    bus_z.rd_addr = {AWZ'(25), AWZ'(0), AWZ'(0)};
    tick();
    checks++;
    if (bus_z.rd_data !== {32'hA5A5_5A5A, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL z_r25 got=%h exp=%h", bus_z.rd_data, {32'hA5A5_5A5A, 32'h0, 32'h0});
    end
    $display("txn ZERO_R0 instance: r0 write/load discarded, r25 written");
  endtask

  task automatic test_back_to_back();
    int a0, a1;
    bit we, lr, lv;
    int wa, lra, lva;
    logic [DW-1:0] wd, ld;
    assert_reset();
    release_reset();
    for (int n = 0; n < 400; n++) begin
      we  = ($urandom_range(0, 1) == 1);
      lr  = ($urandom_range(0, 2) == 0);
      lv  = ($urandom_range(0, 2) == 0);
      wa  = $urandom_range(0, 7);
      lra = $urandom_range(0, 7);
      lva = $urandom_range(0, 7);
      wd  = $urandom;
      ld  = $urandom;
      a0  = $urandom_range(0, NR - 1);
      a1  = $urandom_range(0, NR - 1);
      drive(we, wa, wd, lr, lra, lv, lva, ld);
      bus_a.rd_addr = {AW'(a1), AW'(a0)};
      tick();
      $display("txn %0d we=%0d@%0d lr=%0d@%0d lv=%0d@%0d", n, we, wa, lr, lra, lv, lva);
      checks++;
      if (bus_a.wr_hazard !== m_haz || bus_a.ld_err !== m_err) begin
        failures++;
        $display("FAIL rnd_pulses n=%0d got=%b%b exp=%b%b", n, bus_a.wr_hazard, bus_a.ld_err, m_haz, m_err);
      end
      checks++;
      if (bus_a.pending !== m_pend_vec() || int'(bus_a.pending_cnt) != m_count()) begin
        failures++;
        $display("FAIL rnd_pending n=%0d got=%h/%0d exp=%h/%0d", n, bus_a.pending, bus_a.pending_cnt,
                 m_pend_vec(), m_count());
      end
      checks++;
      if (bus_a.dbg_regs !== m_flat()) begin
        failures++;
        $display("FAIL rnd_regs n=%0d got=%h exp=%h", n, bus_a.dbg_regs, m_flat());
      end
      checks++;
      if (bus_a.rd_data !== {m_regs[a1], m_regs[a0]} ||
          bus_a.rd_busy !== {m_pend[a1], m_pend[a0]}) begin
        failures++;
        $display("FAIL rnd_read n=%0d got=%h/%b exp=%h/%b", n, bus_a.rd_data, bus_a.rd_busy,
                 {m_regs[a1], m_regs[a0]}, {m_pend[a1], m_pend[a0]});
      end
    end
  endtask

  initial begin
    bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_a.ld_req = 1'b0; bus_a.ld_req_addr = '0;
    bus_a.ld_valid = 1'b0; bus_a.ld_rsp_addr = '0; bus_a.ld_data = '0;
    bus_a.rd_addr = '0;
    bus_z.wr_en = 1'b0; bus_z.wr_addr = '0; bus_z.wr_data = '0;
    bus_z.ld_req = 1'b0; bus_z.ld_req_addr = '0;
    bus_z.ld_valid = 1'b0; bus_z.ld_rsp_addr = '0; bus_z.ld_data = '0;
    bus_z.rd_addr = '0;
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_haz = 1'b0;
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    test_reset();
    test_write_read();
    test_waw_hazard();
    test_simultaneous();
    test_reset_mid();
    test_zero_r0();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised, clocked multi-port register file with a load scoreboard. It is the successor to the single-write, two-read CPU register bank and sits between decode/execute (read ports, ALU writeback) and the memory unit (load request/return). Each register carries a pending bit that tracks in-flight loads, so the pipeline can stall on RAW/WAW hazards. An optional write-to-read bypass is available.

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 16, number of architectural registers (power of two, 2..64)
- NUM_RD, 2, number of combinational read ports (1..4)
- ZERO_R0, 0, when 1, register 0 reads as 0 and ignores all writes and load requests
- ADDR_W, $clog2(NUM_REGS), derived; not overridden

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  ALU writeback strobe
- wr_addr  in  ADDR_W  ALU writeback destination
- wr_data  in  DATA_W  ALU writeback data
- ld_req  in  1  load issued; marks ld_req_addr pending
- ld_req_addr  in  ADDR_W  load destination
- ld_valid  in  1  load data returning from memory
- ld_rsp_addr  in  ADDR_W  destination of the returning load
- ld_data  in  DATA_W  returning load data
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data
- rd_busy  out  NUM_RD  read port i addresses a pending register
- pending  out  NUM_REGS  scoreboard vector
- pending_cnt  out  ADDR_W+1  number of set pending bits
- wr_hazard  out  1  one-cycle pulse: ALU write dropped
- ld_err  out  1  one-cycle pulse: ld_req or ld_valid rejected
- dbg_regs  out  NUM_REGS*DATA_W  flat view of all registers, for debug

## Operation
- Reset (async): all registers, pending, pending_cnt, wr_hazard and ld_err go to 0.
- ALU write: wr_en commits wr_data to wr_addr at the next edge, unless pending[wr_addr]=1. In that case the write is dropped and wr_hazard pulses (WAW guard).
- Load request: ld_req sets pending[ld_req_addr]. If that register is already pending and is not being returned in the same cycle, the request is ignored and ld_err pulses.
- Load return: ld_valid writes ld_data into ld_rsp_addr and clears its pending bit. If ld_valid targets a non-pending register, the data is still written and ld_err pulses.
- Simultaneous events:
  - wr_en and ld_valid to the same address: the load wins, and wr_hazard pulses.
  - ld_valid and ld_req to the same address: the data is written and pending stays 1 (new load outstanding).
- pending_cnt always equals popcount(pending). It is a registered counter updated by +1, −1 or 0 per cycle, never recomputed combinationally.
- ZERO_R0=1: writes, ld_req and ld_valid to address 0 are silently discarded, with no error pulse. pending[0] stays 0.
- Reads are combinational from register state. rd_busy[i]=pending[rd_addr_i].

## Timing
- Write latency is 1 cycle: data written at edge N is visible on rd_data after edge N.
- pending, pending_cnt, wr_hazard and ld_err are registered. They change only on a clock edge or on reset.
- There is no backpressure. The memory unit guarantees at most one ld_valid per cycle.
- If reset is asserted mid-operation, all outstanding loads are forgotten. Later ld_valid strobes write their data and pulse ld_err.

## Configuration
- REGFILE_BYPASS_EN is defined: a read address matching a same-cycle committing write returns the new data combinationally. ld_data takes precedence over wr_data. A dropped write is never forwarded. rd_busy is deasserted for an address receiving ld_valid that cycle.
- REGFILE_BYPASS_EN is undefined: rd_data and rd_busy reflect pre-edge state only.

## Structure
- Package regfile_pkg holds:
  - defaults DATA_W_DEF=32, NUM_REGS_DEF=16, NUM_RD_DEF=2
  - the port-slicing helper function for packed rd_addr and rd_data
- Sub-module regfile_rd_port: one read port. It contains the address mux, the optional bypass compare, and the busy lookup. It is instantiated NUM_RD times in a generate loop.

## Test plan
- Reset with all registers preloaded → every dbg_regs word, pending and pending_cnt read 0.
- wr_en=1, wr_addr=3, wr_data=0xDEADBEEF; read port 0 at addr 3 → 0xDEADBEEF one cycle later (same cycle with bypass).
- ld_req addr 5, then wr_en to 5 → wr_hazard pulse, r5 unchanged, rd_busy=1. Then ld_valid addr 5 with data 0x1234 → r5=0x1234, pending_cnt back to 0.
- Same cycle: ld_valid addr 7 (pending), ld_req addr 7, wr_en addr 7 → r7=ld_data, pending[7]=1, wr_hazard=1, pending_cnt unchanged.
- ld_req on 4 distinct registers, then assert reset_n low mid-sequence → pending=0, pending_cnt=0. A later ld_valid to one of them → data written, ld_err=1.
- ZERO_R0=1, NUM_REGS=32, NUM_RD=3: write 0xFFFF_FFFF to r0 → all ports read 0 at addr 0, no error pulse.
